pipeline_hazard_ctrl: RTL and testbench
=======================================

Name: pipeline_hazard_ctrl

Overview:
Central stall/flush/forwarding controller for the 5-stage pipeline. It drives the enable and flush inputs of the PC, IF/ID, ID/EX, EX/MEM and MEM/WB registers. It sequences multi-cycle data-memory accesses through a small FSM and resolves load-use and taken-branch hazards. It also produces EX-stage operand forwarding selects and stall/flush performance counters.

Parameters:
WB_MEM, 2'b00, WBsel encoding meaning "write back load data"
MEM_TIMEOUT, 16, max MEM_WAIT cycles before forced exit and error flag
CNT_W, 32, width of performance counters

Ports:
clk  in  1  clock
reset  in  1  asynchronous active-high reset
rs1_ID  in  5  ID-stage source reg 1
rs2_ID  in  5  ID-stage source reg 2
rs1_use_ID  in  1  ID instruction reads rs1
rs2_use_ID  in  1  ID instruction reads rs2
rd_IDEX  in  5  destination in ID/EX
RegWEn_IDEX  in  1  ID/EX writes a register
WBsel_IDEX  in  2  ID/EX writeback select
rs1_EX  in  5  EX-stage source reg 1
rs2_EX  in  5  EX-stage source reg 2
branch_taken_EX  in  1  EX resolved a taken branch/jump
rd_EXMEM  in  5  destination in EX/MEM
RegWEn_EXMEM  in  1  EX/MEM writes a register
WBsel_EXMEM  in  2  EX/MEM writeback select
MemRW_EXMEM  in  1  EX/MEM is a store
rd_MEMWB  in  5  destination in MEM/WB
RegWEn_MEMWB  in  1  MEM/WB writes a register
dmem_ready  in  1  data memory completes access this cycle
dmem_req  out  1  data memory access request
pc_en  out  1  PC update enable
ifid_en  out  1  IF/ID load enable
idex_en  out  1  ID/EX load enable
exmem_en  out  1  EX/MEM load enable
ifid_flush  out  1  IF/ID clears to NOP
idex_flush  out  1  ID/EX clears to bubble
memwb_bubble  out  1  MEM/WB loads bubble (RegWEn=0)
fwdA_sel  out  2  00 regfile, 01 MEM/WB, 10 EX/MEM ALU result
fwdB_sel  out  2  same encoding for operand B
mem_err  out  1  sticky timeout flag
stall_cycles  out  CNT_W  cycles with pc_en=0
flush_count  out  CNT_W  number of branch flushes

Behaviour:
- Interface: reset reset, asynchronous, active-high; clock clk.
- Reset: state=RUN, timeout counter=0, mem_err=0, stall_cycles=0, flush_count=0. While reset is high, all enables, flushes, memwb_bubble and dmem_req are 0, and fwd selects are 00.
- mem_access = MemRW_EXMEM | (RegWEn_EXMEM & WBsel_EXMEM==WB_MEM).
- FSM states are RUN and MEM_WAIT.
- RUN:
  - dmem_req = mem_access.
  - If mem_access & !dmem_ready: go to MEM_WAIT. This cycle is a stall cycle.
  - Else: normal operation.
- MEM_WAIT:
  - dmem_req = 1 and the timeout counter increments.
  - On dmem_ready: return to RUN and the counter clears. This cycle is not a stall; the pipeline advances.
  - When the counter reaches MEM_TIMEOUT-1 without ready: set mem_err and return to RUN. This cycle advances the pipeline and treats the access as complete.
- Memory stall (RUN with pending miss, or MEM_WAIT without ready/timeout):
  - pc_en=ifid_en=idex_en=exmem_en=0 and memwb_bubble=1.
  - All flushes are suppressed.
- Priority when not memory-stalled:
  - Branch: if branch_taken_EX, then ifid_flush=idex_flush=1, all enables=1, and flush_count+1. Branch overrides load-use because the ID instruction is squashed.
  - Load-use: if RegWEn_IDEX & WBsel_IDEX==WB_MEM & rd_IDEX!=0 & ((rs1_use_ID & rs1_ID==rd_IDEX) | (rs2_use_ID & rs2_ID==rd_IDEX)), then pc_en=ifid_en=0, idex_flush=1, and exmem_en=1. This lasts exactly one cycle and clears naturally next cycle.
  - Otherwise: all enables=1, no flush, no bubble.
- A branch held during a memory stall is acted on in the first non-stalled cycle, because EX is frozen and branch_taken_EX stays asserted.
- Forwarding (combinational, independent of FSM):
  - fwdA_sel=10 if RegWEn_EXMEM & rd_EXMEM!=0 & rd_EXMEM==rs1_EX & WBsel_EXMEM!=WB_MEM.
  - Else fwdA_sel=01 if RegWEn_MEMWB & rd_MEMWB!=0 & rd_MEMWB==rs1_EX.
  - Else fwdA_sel=00.
  - fwdB_sel is identical using rs2_EX. x0 is never forwarded.
- Counters:
  - stall_cycles increments on every cycle with pc_en=0 outside reset.
  - Both counters wrap modulo 2^CNT_W.
  - mem_err clears only on reset.
- Reset asserted mid-MEM_WAIT: immediate return to RUN with dmem_req=0.

Decomposition:
- Package pipe_ctrl_pkg holds: FSM state enum (RUN, MEM_WAIT), WB_MEM/WB_ALU/WB_PC4 constants, and FWD_RF/FWD_MEMWB/FWD_EXMEM select constants.
- Sub-module forwarding_unit is purely combinational and produces fwdA_sel/fwdB_sel. It is instantiated once.

Test Plan:
- Load-use: ID/EX lw x5 (WBsel=00, RegWEn=1), ID add reading rs1=x5 -> one cycle with pc_en=0, ifid_en=0, idex_flush=1; next cycle all enables=1; stall_cycles=1.
- Branch: branch_taken_EX=1 for one cycle -> ifid_flush=idex_flush=1, pc_en=1, flush_count=1; same cycle with a load-use also present -> pc_en=1 (branch wins).
- Memory wait: store in EX/MEM, dmem_ready low 3 cycles then high -> dmem_req high 4 cycles, enables 0 and memwb_bubble=1 for 3 cycles, advance on cycle 4, stall_cycles=3.
- Timeout: MEM_TIMEOUT=4, dmem_ready never high -> mem_err=1 after 4 cycles, FSM in RUN, pipeline advances; mem_err stays 1 until reset.
- Forwarding: rd_EXMEM=rd_MEMWB=x7, both RegWEn=1, rs1_EX=x7 -> fwdA_sel=10; EX/MEM is a load -> 01; rd=x0 -> 00.
- Async reset pulse during MEM_WAIT -> outputs 0 immediately, counters 0, state RUN after release.

Source files
------------

// File: rtl/pipeline_hazard_ctrl_pkg.sv
// Shared types and encodings for the pipeline hazard controller.
package pipe_ctrl_pkg;

  typedef enum logic [0:0] {
    RUN      = 1'b0,
    MEM_WAIT = 1'b1
  } state_e;

  localparam logic [1:0] WB_MEM = 2'b00;
  localparam logic [1:0] WB_ALU = 2'b01;
  localparam logic [1:0] WB_PC4 = 2'b10;

  localparam logic [1:0] FWD_RF    = 2'b00;
  localparam logic [1:0] FWD_MEMWB = 2'b01;
  localparam logic [1:0] FWD_EXMEM = 2'b10;

  // A producer matches a consumer only if it really writes a non-x0 register.
  function automatic logic reg_match(input logic wen, input logic [4:0] rd, input logic [4:0] rs);
    return wen & (rd != 5'd0) & (rd == rs);
  endfunction

endpackage

// File: rtl/pipeline_hazard_ctrl_forwarding_unit.sv
// EX-stage operand bypass selection; EX/MEM wins over MEM/WB, loads in EX/MEM cannot forward.
module forwarding_unit
  import pipe_ctrl_pkg::*;
(
  input  logic [4:0] rs1_EX,
  input  logic [4:0] rs2_EX,
  input  logic [4:0] rd_EXMEM,
  input  logic       RegWEn_EXMEM,
  input  logic [1:0] WBsel_EXMEM,
  input  logic [4:0] rd_MEMWB,
  input  logic       RegWEn_MEMWB,
  output logic [1:0] fwdA_sel,
  output logic [1:0] fwdB_sel
);

  logic exmem_alu_s;

  // Operand select priority for both EX source registers.
  always_comb begin
    exmem_alu_s = RegWEn_EXMEM & (WBsel_EXMEM != WB_MEM);
    if (reg_match(exmem_alu_s, rd_EXMEM, rs1_EX)) begin
      fwdA_sel = FWD_EXMEM;
    end else if (reg_match(RegWEn_MEMWB, rd_MEMWB, rs1_EX)) begin
      fwdA_sel = FWD_MEMWB;
    end else begin
      fwdA_sel = FWD_RF;
    end
    if (reg_match(exmem_alu_s, rd_EXMEM, rs2_EX)) begin
      fwdB_sel = FWD_EXMEM;
    end else if (reg_match(RegWEn_MEMWB, rd_MEMWB, rs2_EX)) begin
      fwdB_sel = FWD_MEMWB;
    end else begin
      fwdB_sel = FWD_RF;
    end
  end

endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// Stall/flush/forwarding controller for the 5-stage pipeline, with a two-state
// data-memory wait sequencer and stall/flush performance counters.
module pipeline_hazard_ctrl
  import pipe_ctrl_pkg::*;
#(
  parameter int MEM_TIMEOUT = 16,
  parameter int CNT_W       = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [4:0]       rs1_ID,
  input  logic [4:0]       rs2_ID,
  input  logic             rs1_use_ID,
  input  logic             rs2_use_ID,
  input  logic [4:0]       rd_IDEX,
  input  logic             RegWEn_IDEX,
  input  logic [1:0]       WBsel_IDEX,
  input  logic [4:0]       rs1_EX,
  input  logic [4:0]       rs2_EX,
  input  logic             branch_taken_EX,
  input  logic [4:0]       rd_EXMEM,
  input  logic             RegWEn_EXMEM,
  input  logic [1:0]       WBsel_EXMEM,
  input  logic             MemRW_EXMEM,
  input  logic [4:0]       rd_MEMWB,
  input  logic             RegWEn_MEMWB,
  input  logic             dmem_ready,
  output logic             dmem_req,
  output logic             pc_en,
  output logic             ifid_en,
  output logic             idex_en,
  output logic             exmem_en,
  output logic             ifid_flush,
  output logic             idex_flush,
  output logic             memwb_bubble,
  output logic [1:0]       fwdA_sel,
  output logic [1:0]       fwdB_sel,
  output logic             mem_err,
  output logic [CNT_W-1:0] stall_cycles,
  output logic [CNT_W-1:0] flush_count
);

  localparam int TW = (MEM_TIMEOUT > 2) ? $clog2(MEM_TIMEOUT) : 1;
  localparam logic [TW-1:0] TMO_LAST = TW'(MEM_TIMEOUT - 1);

  state_e           state_q, state_d;
  logic [TW-1:0]    tmo_q, tmo_d;
  logic             mem_err_q, mem_err_d;
  logic [CNT_W-1:0] stall_q, stall_d;
  logic [CNT_W-1:0] flush_q, flush_d;

  logic       mem_access_s, load_use_s, mem_stall_s, dmem_req_s;
  logic       pc_en_s, ifid_en_s, idex_en_s, exmem_en_s;
  logic       ifid_flush_s, idex_flush_s, bubble_s;
  logic [1:0] fwd_a_s, fwd_b_s;

  forwarding_unit u_fwd (
    .rs1_EX       (rs1_EX),
    .rs2_EX       (rs2_EX),
    .rd_EXMEM     (rd_EXMEM),
    .RegWEn_EXMEM (RegWEn_EXMEM),
    .WBsel_EXMEM  (WBsel_EXMEM),
    .rd_MEMWB     (rd_MEMWB),
    .RegWEn_MEMWB (RegWEn_MEMWB),
    .fwdA_sel     (fwd_a_s),
    .fwdB_sel     (fwd_b_s)
  );

  // Memory sequencer next state plus the resulting stall decision.
  always_comb begin
    mem_access_s = MemRW_EXMEM | (RegWEn_EXMEM & (WBsel_EXMEM == WB_MEM));
    state_d      = state_q;
    tmo_d        = tmo_q;
    mem_err_d    = mem_err_q;
    mem_stall_s  = 1'b0;
    dmem_req_s   = 1'b0;
    case (state_q)
      RUN: begin
        dmem_req_s  = mem_access_s;
        mem_stall_s = mem_access_s & ~dmem_ready;
        tmo_d       = '0;
        if (mem_stall_s) begin
          state_d = MEM_WAIT;
        end else begin
          state_d = RUN;
        end
      end
      MEM_WAIT: begin
        dmem_req_s = 1'b1;
        if (dmem_ready) begin
          state_d = RUN;
          tmo_d   = '0;
        end else if (tmo_q == TMO_LAST) begin
          // Give up on the access: release the pipeline and flag it.
          state_d   = RUN;
          tmo_d     = '0;
          mem_err_d = 1'b1;
        end else begin
          mem_stall_s = 1'b1;
          tmo_d       = tmo_q + TW'(1);
        end
      end
      default: begin
        state_d = RUN;
        tmo_d   = '0;
      end
    endcase
  end

  // Pipeline register controls: memory stall > taken branch > load-use.
  always_comb begin
    load_use_s = RegWEn_IDEX & (WBsel_IDEX == WB_MEM) & (rd_IDEX != 5'd0) &
                 ((rs1_use_ID & (rs1_ID == rd_IDEX)) | (rs2_use_ID & (rs2_ID == rd_IDEX)));
    pc_en_s      = 1'b1;
    ifid_en_s    = 1'b1;
    idex_en_s    = 1'b1;
    exmem_en_s   = 1'b1;
    ifid_flush_s = 1'b0;
    idex_flush_s = 1'b0;
    bubble_s     = 1'b0;
    if (reset) begin
      pc_en_s    = 1'b0;
      ifid_en_s  = 1'b0;
      idex_en_s  = 1'b0;
      exmem_en_s = 1'b0;
    end else if (mem_stall_s) begin
      pc_en_s    = 1'b0;
      ifid_en_s  = 1'b0;
      idex_en_s  = 1'b0;
      exmem_en_s = 1'b0;
      bubble_s   = 1'b1;
    end else if (branch_taken_EX) begin
      ifid_flush_s = 1'b1;
      idex_flush_s = 1'b1;
    end else if (load_use_s) begin
      pc_en_s      = 1'b0;
      ifid_en_s    = 1'b0;
      idex_flush_s = 1'b1;
    end else begin
      pc_en_s = 1'b1;
    end
    stall_d = pc_en_s ? stall_q : stall_q + CNT_W'(1);
    flush_d = (branch_taken_EX & ~mem_stall_s) ? flush_q + CNT_W'(1) : flush_q;
  end

  // State, timeout and counter registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= RUN;
      tmo_q     <= '0;
      mem_err_q <= 1'b0;
      stall_q   <= '0;
      flush_q   <= '0;
    end else begin
      state_q   <= state_d;
      tmo_q     <= tmo_d;
      mem_err_q <= mem_err_d;
      stall_q   <= stall_d;
      flush_q   <= flush_d;
    end
  end

  assign dmem_req     = dmem_req_s & ~reset;
  assign pc_en        = pc_en_s;
  assign ifid_en      = ifid_en_s;
  assign idex_en      = idex_en_s;
  assign exmem_en     = exmem_en_s;
  assign ifid_flush   = ifid_flush_s;
  assign idex_flush   = idex_flush_s;
  assign memwb_bubble = bubble_s;
  assign fwdA_sel     = reset ? FWD_RF : fwd_a_s;
  assign fwdB_sel     = reset ? FWD_RF : fwd_b_s;
  assign mem_err      = mem_err_q;
  assign stall_cycles = stall_q;
  assign flush_count  = flush_q;

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Self-checking bench for pipeline_hazard_ctrl: directed scenarios plus a random
// run against a cycle-level behavioural model.
module tb_pipeline_hazard_ctrl;

  localparam int TO = 4;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic [4:0] rs1_ID, rs2_ID, rd_IDEX, rs1_EX, rs2_EX, rd_EXMEM, rd_MEMWB;
  logic rs1_use_ID, rs2_use_ID, RegWEn_IDEX, branch_taken_EX, RegWEn_EXMEM;
  logic MemRW_EXMEM, RegWEn_MEMWB, dmem_ready;
  logic [1:0] WBsel_IDEX, WBsel_EXMEM;
  logic dmem_req, pc_en, ifid_en, idex_en, exmem_en, ifid_flush, idex_flush, memwb_bubble;
  logic [1:0] fwdA_sel, fwdB_sel;
  logic mem_err;
  logic [31:0] stall_cycles, flush_count;
  logic [7:0] ctrl;

  int n_cmp = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  assign ctrl = {dmem_req, pc_en, ifid_en, idex_en, exmem_en, ifid_flush, idex_flush, memwb_bubble};

  pipeline_hazard_ctrl #(.MEM_TIMEOUT(TO), .CNT_W(32)) dut (
    .clk(clk), .reset(reset),
    .rs1_ID(rs1_ID), .rs2_ID(rs2_ID), .rs1_use_ID(rs1_use_ID), .rs2_use_ID(rs2_use_ID),
    .rd_IDEX(rd_IDEX), .RegWEn_IDEX(RegWEn_IDEX), .WBsel_IDEX(WBsel_IDEX),
    .rs1_EX(rs1_EX), .rs2_EX(rs2_EX), .branch_taken_EX(branch_taken_EX),
    .rd_EXMEM(rd_EXMEM), .RegWEn_EXMEM(RegWEn_EXMEM), .WBsel_EXMEM(WBsel_EXMEM),
    .MemRW_EXMEM(MemRW_EXMEM), .rd_MEMWB(rd_MEMWB), .RegWEn_MEMWB(RegWEn_MEMWB),
    .dmem_ready(dmem_ready), .dmem_req(dmem_req), .pc_en(pc_en), .ifid_en(ifid_en),
    .idex_en(idex_en), .exmem_en(exmem_en), .ifid_flush(ifid_flush),
    .idex_flush(idex_flush), .memwb_bubble(memwb_bubble), .fwdA_sel(fwdA_sel),
    .fwdB_sel(fwdB_sel), .mem_err(mem_err), .stall_cycles(stall_cycles),
    .flush_count(flush_count)
  );

  task automatic drive_idle();
    rs1_ID = 5'd0; rs2_ID = 5'd0; rs1_use_ID = 1'b0; rs2_use_ID = 1'b0;
    rd_IDEX = 5'd0; RegWEn_IDEX = 1'b0; WBsel_IDEX = 2'b01;
    rs1_EX = 5'd0; rs2_EX = 5'd0; branch_taken_EX = 1'b0;
    rd_EXMEM = 5'd0; RegWEn_EXMEM = 1'b0; WBsel_EXMEM = 2'b01; MemRW_EXMEM = 1'b0;
    rd_MEMWB = 5'd0; RegWEn_MEMWB = 1'b0; dmem_ready = 1'b1;
  endtask

  // Leaves the bench at a negedge with reset released and idle inputs.
  task automatic do_reset();
    reset = 1'b1;
    drive_idle();
    repeat (2) @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic set_load_use();
    RegWEn_IDEX = 1'b1; WBsel_IDEX = 2'b00; rd_IDEX = 5'd5;
    rs1_ID = 5'd5; rs1_use_ID = 1'b1; rs2_ID = 5'd9; rs2_use_ID = 1'b1;
  endtask

  task automatic test_reset();
    drive_idle();
    reset = 1'b1;
    RegWEn_EXMEM = 1'b1; rd_EXMEM = 5'd3; rs1_EX = 5'd3; rs2_EX = 5'd3;
    MemRW_EXMEM = 1'b1; dmem_ready = 1'b0; branch_taken_EX = 1'b1;
    @(negedge clk); #1;
    n_cmp++; if (ctrl !== 8'b0) begin n_fail++; $display("FAIL reset_ctrl got %b exp %b", ctrl, 8'b0); end
    n_cmp++; if ({fwdA_sel, fwdB_sel} !== 4'b0) begin n_fail++; $display("FAIL reset_fwd got %b exp 0000", {fwdA_sel, fwdB_sel}); end
    n_cmp++; if ({stall_cycles, flush_count, mem_err} !== 65'd0) begin n_fail++; $display("FAIL reset_regs got %0d %0d %b exp 0 0 0", stall_cycles, flush_count, mem_err); end
    @(negedge clk);
    drive_idle();
    reset = 1'b0;
    #1;
    n_cmp++; if (ctrl !== 8'b0111_1000) begin n_fail++; $display("FAIL reset_release got %b exp %b", ctrl, 8'b0111_1000); end
    @(posedge clk); #1;
    n_cmp++; if (stall_cycles !== 32'd0) begin n_fail++; $display("FAIL reset_stall got %0d exp 0", stall_cycles); end
    @(negedge clk);
  endtask

  task automatic test_load_use();
    do_reset();
    set_load_use();
    #1;
    n_cmp++; if (ctrl !== 8'b0001_1010) begin n_fail++; $display("FAIL lu_ctrl got %b exp %b", ctrl, 8'b0001_1010); end
    @(posedge clk); #1;
    n_cmp++; if (stall_cycles !== 32'd1) begin n_fail++; $display("FAIL lu_stall got %0d exp 1", stall_cycles); end
    @(negedge clk);
    RegWEn_IDEX = 1'b0;
    #1;
    n_cmp++; if (ctrl !== 8'b0111_1000) begin n_fail++; $display("FAIL lu_next got %b exp %b", ctrl, 8'b0111_1000); end
    @(negedge clk);
    RegWEn_IDEX = 1'b1; rd_IDEX = 5'd0; rs1_ID = 5'd0;
    #1;
    n_cmp++; if (ctrl !== 8'b0111_1000) begin n_fail++; $display("FAIL lu_x0 got %b exp %b", ctrl, 8'b0111_1000); end
    @(posedge clk); #1;
    n_cmp++; if (stall_cycles !== 32'd1) begin n_fail++; $display("FAIL lu_stall_end got %0d exp 1", stall_cycles); end
    @(negedge clk);
  endtask

  task automatic test_branch();
    do_reset();
    branch_taken_EX = 1'b1;
    #1;
    n_cmp++; if (ctrl !== 8'b0111_1110) begin n_fail++; $display("FAIL br_ctrl got %b exp %b", ctrl, 8'b0111_1110); end
    @(posedge clk); #1;
    n_cmp++; if (flush_count !== 32'd1) begin n_fail++; $display("FAIL br_count got %0d exp 1", flush_count); end
    @(negedge clk);
    set_load_use();
    #1;
    n_cmp++; if (ctrl !== 8'b0111_1110) begin n_fail++; $display("FAIL br_over_lu got %b exp %b", ctrl, 8'b0111_1110); end
    @(posedge clk); #1;
    n_cmp++; if ({flush_count, stall_cycles} !== {32'd2, 32'd0}) begin n_fail++; $display("FAIL br_counts got %0d %0d exp 2 0", flush_count, stall_cycles); end
    @(negedge clk);
    branch_taken_EX = 1'b0;
    #1;
    n_cmp++; if (ctrl !== 8'b0001_1010) begin n_fail++; $display("FAIL br_then_lu got %b exp %b", ctrl, 8'b0001_1010); end
    @(negedge clk);
  endtask

  task automatic test_mem_wait();
    do_reset();
    MemRW_EXMEM = 1'b1; dmem_ready = 1'b0; branch_taken_EX = 1'b1;
    for (int i = 0; i < 3; i++) begin
      #1;
      n_cmp++; if (ctrl !== 8'b1000_0001) begin n_fail++; $display("FAIL mw_stall%0d got %b exp %b", i, ctrl, 8'b1000_0001); end
      @(negedge clk);
    end
    dmem_ready = 1'b1;
    #1;
    n_cmp++; if (ctrl !== 8'b1111_1110) begin n_fail++; $display("FAIL mw_done got %b exp %b", ctrl, 8'b1111_1110); end
    @(posedge clk); #1;
    n_cmp++; if ({stall_cycles, flush_count} !== {32'd3, 32'd1}) begin n_fail++; $display("FAIL mw_counts got %0d %0d exp 3 1", stall_cycles, flush_count); end
    @(negedge clk);
    drive_idle();
    #1;
    n_cmp++; if (ctrl !== 8'b0111_1000) begin n_fail++; $display("FAIL mw_after got %b exp %b", ctrl, 8'b0111_1000); end
    @(negedge clk);
  endtask

  task automatic test_forwarding();
    do_reset();
    rd_EXMEM = 5'd7; RegWEn_EXMEM = 1'b1; WBsel_EXMEM = 2'b01;
    rd_MEMWB = 5'd7; RegWEn_MEMWB = 1'b1; rs1_EX = 5'd7; rs2_EX = 5'd7;
    #1;
    n_cmp++; if ({fwdA_sel, fwdB_sel} !== 4'b1010) begin n_fail++; $display("FAIL fwd_exmem got %b exp 1010", {fwdA_sel, fwdB_sel}); end
    @(negedge clk);
    WBsel_EXMEM = 2'b00;
    #1;
    n_cmp++; if ({fwdA_sel, fwdB_sel} !== 4'b0101) begin n_fail++; $display("FAIL fwd_load got %b exp 0101", {fwdA_sel, fwdB_sel}); end
    @(negedge clk);
    WBsel_EXMEM = 2'b01; rs2_EX = 5'd4;
    #1;
    n_cmp++; if ({fwdA_sel, fwdB_sel} !== 4'b1000) begin n_fail++; $display("FAIL fwd_mixed got %b exp 1000", {fwdA_sel, fwdB_sel}); end
    @(negedge clk);
    rd_EXMEM = 5'd0; rd_MEMWB = 5'd0; rs1_EX = 5'd0; rs2_EX = 5'd0;
    #1;
    n_cmp++; if ({fwdA_sel, fwdB_sel} !== 4'b0000) begin n_fail++; $display("FAIL fwd_x0 got %b exp 0000", {fwdA_sel, fwdB_sel}); end
    @(negedge clk);
  endtask

  task automatic test_timeout();
    do_reset();
    MemRW_EXMEM = 1'b1; dmem_ready = 1'b0;
    for (int i = 0; i < TO; i++) begin
      #1;
      n_cmp++; if (ctrl !== 8'b1000_0001) begin n_fail++; $display("FAIL to_stall%0d got %b exp %b", i, ctrl, 8'b1000_0001); end
      @(posedge clk); #1;
      n_cmp++; if (mem_err !== 1'b0) begin n_fail++; $display("FAIL to_early%0d got %b exp 0", i, mem_err); end
      @(negedge clk);
    end
    #1;
    n_cmp++; if (ctrl !== 8'b1111_1000) begin n_fail++; $display("FAIL to_exit got %b exp %b", ctrl, 8'b1111_1000); end
    @(posedge clk); #1;
    n_cmp++; if ({mem_err, stall_cycles} !== {1'b1, 32'd4}) begin n_fail++; $display("FAIL to_err got %b %0d exp 1 4", mem_err, stall_cycles); end
    @(negedge clk);
    MemRW_EXMEM = 1'b0;
    #1;
    n_cmp++; if (ctrl !== 8'b0111_1000) begin n_fail++; $display("FAIL to_run got %b exp %b", ctrl, 8'b0111_1000); end
    repeat (2) @(posedge clk);
    #1;
    n_cmp++; if (mem_err !== 1'b1) begin n_fail++; $display("FAIL to_sticky got %b exp 1", mem_err); end
    @(negedge clk);
  endtask

  task automatic test_async_reset();
    MemRW_EXMEM = 1'b1; dmem_ready = 1'b0;
    @(negedge clk);
    #1;
    n_cmp++; if (ctrl !== 8'b1000_0001) begin n_fail++; $display("FAIL ar_wait got %b exp %b", ctrl, 8'b1000_0001); end
    #2 reset = 1'b1;
    #1;
    n_cmp++; if (ctrl !== 8'b0) begin n_fail++; $display("FAIL ar_ctrl got %b exp 0", ctrl); end
    n_cmp++; if ({mem_err, stall_cycles, flush_count} !== 65'd0) begin n_fail++; $display("FAIL ar_regs got %b %0d %0d exp 0 0 0", mem_err, stall_cycles, flush_count); end
    @(negedge clk);
    reset = 1'b0; MemRW_EXMEM = 1'b0;
    #1;
    n_cmp++; if (ctrl !== 8'b0111_1000) begin n_fail++; $display("FAIL ar_run got %b exp %b", ctrl, 8'b0111_1000); end
    @(negedge clk);
  endtask

  function automatic logic [1:0] ref_fwd(input logic [4:0] rs);
    if (RegWEn_EXMEM && rd_EXMEM != 0 && rd_EXMEM == rs && WBsel_EXMEM != 2'b00) return 2'b10;
    if (RegWEn_MEMWB && rd_MEMWB != 0 && rd_MEMWB == rs) return 2'b01;
    return 2'b00;
  endfunction

  task automatic test_random();
    bit in_wait = 0;
    int waited = 0;
    bit m_err = 0;
    logic [31:0] m_stall = 0, m_flush = 0;
    bit macc, lu, mst, req;
    logic [7:0] exp_ctrl;
    logic [1:0] ea, eb;
    do_reset();
    for (int c = 0; c < 400; c++) begin
      rs1_ID = 5'($urandom_range(0, 3)); rs2_ID = 5'($urandom_range(0, 3));
      rs1_use_ID = 1'($urandom); rs2_use_ID = 1'($urandom);
      rd_IDEX = 5'($urandom_range(0, 3)); RegWEn_IDEX = 1'($urandom);
      WBsel_IDEX = 2'($urandom_range(0, 2));
      rs1_EX = 5'($urandom_range(0, 3)); rs2_EX = 5'($urandom_range(0, 3));
      branch_taken_EX = ($urandom_range(0, 4) == 0);
      rd_EXMEM = 5'($urandom_range(0, 3)); RegWEn_EXMEM = 1'($urandom);
      WBsel_EXMEM = 2'($urandom_range(0, 2)); MemRW_EXMEM = ($urandom_range(0, 3) == 0);
      rd_MEMWB = 5'($urandom_range(0, 3)); RegWEn_MEMWB = 1'($urandom);
      dmem_ready = ($urandom_range(0, 2) == 0);
      macc = MemRW_EXMEM || (RegWEn_EXMEM && WBsel_EXMEM == 2'b00);
      lu = RegWEn_IDEX && WBsel_IDEX == 2'b00 && rd_IDEX != 0 &&
           ((rs1_use_ID && rs1_ID == rd_IDEX) || (rs2_use_ID && rs2_ID == rd_IDEX));
      mst = in_wait ? (!dmem_ready && waited < TO - 1) : (macc && !dmem_ready);
      req = in_wait || macc;
      if (mst) exp_ctrl = {req, 7'b000_0001};
      else if (branch_taken_EX) exp_ctrl = {req, 7'b111_1110};
      else if (lu) exp_ctrl = {req, 7'b001_1010};
      else exp_ctrl = {req, 7'b111_1000};
      ea = ref_fwd(rs1_EX);
      eb = ref_fwd(rs2_EX);
      #1;
      n_cmp++; if (ctrl !== exp_ctrl) begin n_fail++; $display("FAIL rnd_ctrl c%0d got %b exp %b", c, ctrl, exp_ctrl); end
      n_cmp++; if ({fwdA_sel, fwdB_sel} !== {ea, eb}) begin n_fail++; $display("FAIL rnd_fwd c%0d got %b exp %b", c, {fwdA_sel, fwdB_sel}, {ea, eb}); end
      if (!exp_ctrl[6]) m_stall++;
      if (!mst && branch_taken_EX) m_flush++;
      if (!in_wait) begin
        if (macc && !dmem_ready) begin in_wait = 1; waited = 0; end
      end else if (dmem_ready) begin
        in_wait = 0;
      end else if (waited == TO - 1) begin
        in_wait = 0; m_err = 1;
      end else begin
        waited++;
      end
      @(posedge clk); #1;
      n_cmp++; if ({mem_err, stall_cycles, flush_count} !== {m_err, m_stall, m_flush}) begin
        n_fail++; $display("FAIL rnd_regs c%0d got %b %0d %0d exp %b %0d %0d", c, mem_err, stall_cycles, flush_count, m_err, m_stall, m_flush);
      end
      @(negedge clk);
    end
  endtask

  initial begin
    test_reset();
    test_load_use();
    test_branch();
    test_mem_wait();
    test_forwarding();
    test_timeout();
    test_async_reset();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
